// File: rtl/cfa_window_buffer_if.sv
// Pixel-in / window-out bundle for the CFA window buffer.
// The master side drives the pixel stream and the slave side drives the window.
interface cfa_window_buffer_if #(
  parameter int PIX_W = 8,
  parameter int K     = 3,
  parameter int CW    = 12
);
  logic                   en;
  logic                   sof;
  logic [CW-1:0]          line_width;
  logic [PIX_W-1:0]       d_in;
  logic [K*K*PIX_W-1:0]   window_data;
  logic                   win_valid;
  logic [CW-1:0]          ctr_row;
  logic [CW-1:0]          ctr_col;
  logic [1:0]             bayer_phase;

  modport master (
    output en, sof, line_width, d_in,
    input  window_data, win_valid, ctr_row, ctr_col, bayer_phase
  );

  modport slave (
    input  en, sof, line_width, d_in,
    output window_data, win_valid, ctr_row, ctr_col, bayer_phase
  );
endinterface

// File: rtl/cfa_window_buffer.sv
// CFA KxK neighbourhood buffer: K-1 line memories chained as a vertical
// shift, feeding a KxK register window. Every accepted pixel shifts the
// window one column left and loads a fresh column; output latency is 1 clock.

// One line of pixel storage. The read is asynchronous, so the value seen
// during an accept cycle is the old contents (read-before-write).
module cfa_line_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wd_i,
  output logic [DW-1:0] rd_o
);
  logic [DW-1:0] mem_q [DEPTH];

  assign rd_o = mem_q[addr_i];

  // Single write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wd_i;
  end
endmodule

module cfa_window_buffer #(
  parameter int PIX_W = 8,
  parameter int K     = 3,
  parameter int IMG_W = 640,
  parameter int CW    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  cfa_window_buffer_if.slave    bus
);
  localparam int NL = K - 1;
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] KM1  = CW'(K - 1);
  localparam logic [CW-1:0] HALF = CW'((K - 1) / 2);
  localparam logic [CW-1:0] WMAX = CW'(IMG_W);
  localparam logic [CW-1:0] RMAX = '1;

  // Raster position of the pixel arriving next, plus the active line width.
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] width_q, width_d;

  // Position/width of the pixel on d_in this cycle (sof overrides state).
  logic [CW-1:0] cur_c, cur_r, cur_w, sof_w;

  // Window and its qualifiers.
  logic [K-1:0][K-1:0][PIX_W-1:0] win_q, win_d;
  logic                           vld_q, vld_d;
  logic [CW-1:0]                  ctr_row_q, ctr_row_d;
  logic [CW-1:0]                  ctr_col_q, ctr_col_d;

  // Column entering the window: index 0 = oldest row, K-1 = d_in.
  logic [K-1:0][PIX_W-1:0] colv;
  logic [NL-1:0][PIX_W-1:0] rd;

  assign colv[K-1] = bus.d_in;

  // Memory j holds row r-K+1+j; on accept it takes the row below it, so
  // each column moves up one line per line period.
  for (genvar j = 0; j < NL; j++) begin : g_lm
    assign colv[j] = rd[j];
    cfa_line_mem #(.DW(PIX_W), .DEPTH(IMG_W), .AW(AW)) u_lm (
      .clk   (clk),
      .we_i  (bus.en),
      .addr_i(cur_c[AW-1:0]),
      .wd_i  (colv[j+1]),
      .rd_o  (rd[j])
    );
  end

  // Width loaded at sof: out-of-range requests fall back to the full line.
  assign sof_w = ((bus.line_width == '0) || (bus.line_width > WMAX)) ? WMAX
                                                                      : bus.line_width;

  // Position bookkeeping: sof restarts at (0,0), wrap at width-1, row saturates.
  always_comb begin
    cur_c   = col_q;
    cur_r   = row_q;
    cur_w   = width_q;
    col_d   = col_q;
    row_d   = row_q;
    width_d = width_q;
    if (bus.sof) begin
      cur_c = '0;
      cur_r = '0;
      cur_w = sof_w;
    end
    if (bus.en) begin
      width_d = cur_w;
      if (cur_c == cur_w - 1'b1) begin
        col_d = '0;
        row_d = (cur_r == RMAX) ? cur_r : cur_r + 1'b1;
      end else begin
        col_d = cur_c + 1'b1;
        row_d = cur_r;
      end
    end
  end

  // Window shift and output qualifiers; everything holds while en is low.
  always_comb begin
    win_d     = win_q;
    vld_d     = 1'b0;
    ctr_row_d = ctr_row_q;
    ctr_col_d = ctr_col_q;
    if (bus.en) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = colv[r];
      end
      vld_d     = (cur_r >= KM1) && (cur_c >= KM1);
      ctr_row_d = cur_r - HALF;
      ctr_col_d = cur_c - HALF;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      width_q   <= WMAX;
      win_q     <= '0;
      vld_q     <= 1'b0;
      ctr_row_q <= '0;
      ctr_col_q <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      width_q   <= width_d;
      win_q     <= win_d;
      vld_q     <= vld_d;
      ctr_row_q <= ctr_row_d;
      ctr_col_q <= ctr_col_d;
    end
  end

  assign bus.window_data = win_q;
  assign bus.win_valid   = vld_q;
  assign bus.ctr_row     = ctr_row_q;
  assign bus.ctr_col     = ctr_col_q;
  assign bus.bayer_phase = {ctr_row_q[0], ctr_col_q[0]};
endmodule

// File: tb/tb_cfa_window_buffer.sv
// Directed bench for cfa_window_buffer (K=3, PIX_W=8, IMG_W=8). A position
// model predicts each cycle's outputs into a queue; they are popped and
// compared one clock later. Window elements whose source pixel is outside
// the current frame/line (stale columns, unwritten rows) are masked.
module tb_cfa_window_buffer;
  localparam int PIX_W = 8;
  localparam int K     = 3;
  localparam int IMG_W = 8;
  localparam int CW    = 12;
  localparam int WB    = K * K * PIX_W;

  typedef struct {
    logic          vld;
    logic [CW-1:0] cr;
    logic [CW-1:0] cc;
    logic [1:0]    ph;
    logic [WB-1:0] win;
    logic [WB-1:0] msk;
  } exp_t;

  logic clk;
  logic rst;
  cfa_window_buffer_if #(.PIX_W(PIX_W), .K(K), .CW(CW)) bus ();

  cfa_window_buffer #(.PIX_W(PIX_W), .K(K), .IMG_W(IMG_W), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  string tag      = "init";
  exp_t  sbq[$];

  // Reference model state.
  int         mr, mc, mw;
  logic [7:0] img [16][16];
  bit         imgk[16][16];
  exp_t       last;

  task automatic model_reset();
    mr = 0; mc = 0; mw = IMG_W;
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) imgk[i][j] = 0;
    last.vld = 0; last.cr = '0; last.cc = '0; last.ph = '0;
    last.win = '0; last.msk = '1;
  endtask

  task automatic model(input logic e, input logic s, input logic [CW-1:0] lw,
                       input logic [7:0] d, output exp_t x);
    x = last;
    x.vld = 1'b0;
    if (e) begin
      if (s) begin
        mr = 0; mc = 0;
        mw = (lw == 0 || lw > IMG_W) ? IMG_W : int'(lw);
        for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) imgk[i][j] = 0;
      end
      if (mr < 16) begin img[mr][mc] = d; imgk[mr][mc] = 1; end
      x.vld = (mr >= 2) && (mc >= 2);
      x.cr  = CW'(mr - 1);
      x.cc  = CW'(mc - 1);
      x.ph  = {x.cr[0], x.cc[0]};
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          int rr, cc2, idx;
          rr = mr - 2 + i; cc2 = mc - 2 + j; idx = (i * K + j) * PIX_W;
          if (rr >= 0 && cc2 >= 0 && rr < 16 && imgk[rr][cc2]) begin
            x.win[idx +: PIX_W] = img[rr][cc2];
            x.msk[idx +: PIX_W] = 8'hFF;
          end else begin
            x.win[idx +: PIX_W] = 8'h00;
            x.msk[idx +: PIX_W] = 8'h00;
          end
        end
      end
      if (mc == mw - 1) begin
        mc = 0;
        if (mr < (1 << CW) - 1) mr++;
      end else mc++;
    end
    last = x;
  endtask

  task automatic check();
    exp_t x;
    checks++;
    assert (sbq.size() > 0) else begin
      failures++;
      $error("FAIL %s sb_empty got=%0d exp=>0", tag, sbq.size());
    end
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      checks++;
      assert (bus.win_valid === x.vld) else begin
        failures++;
        $error("FAIL %s win_valid got=%0b exp=%0b", tag, bus.win_valid, x.vld);
      end
      checks++;
      assert ({bus.ctr_row, bus.ctr_col} === {x.cr, x.cc}) else begin
        failures++;
        $error("FAIL %s ctr got=(%0d,%0d) exp=(%0d,%0d)", tag, bus.ctr_row, bus.ctr_col, x.cr, x.cc);
      end
      checks++;
      assert (bus.bayer_phase === x.ph) else begin
        failures++;
        $error("FAIL %s bayer_phase got=%b exp=%b", tag, bus.bayer_phase, x.ph);
      end
      checks++;
      assert ((bus.window_data & x.msk) === (x.win & x.msk)) else begin
        failures++;
        $error("FAIL %s window got=%h exp=%h mask=%h", tag, bus.window_data & x.msk, x.win, x.msk);
      end
    end
  endtask

  task automatic step(input logic e, input logic s, input logic [CW-1:0] lw, input logic [7:0] d);
    exp_t x;
    @(negedge clk);
    rst = 1'b0; bus.en = e; bus.sof = s; bus.line_width = lw; bus.d_in = d;
    model(e, s, lw, d, x);
    sbq.push_back(x);
    @(posedge clk); #1;
    check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.en = 1'b0; bus.sof = 1'b0;
    model_reset();
    sbq.push_back(last);
    @(posedge clk); #1;
    check();
  endtask

  // Plan scenario: width 4, 4 lines, pixel = 16r+c, optional en gap before (2,2).
  task automatic frame4(input bit gap, input int stop_after);
    int k;
    k = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (k < stop_after) begin
          if (gap && r == 2 && c == 2) begin
            step(1'b0, 1'b0, 12'd4, 8'hAA);
            step(1'b0, 1'b1, 12'd7, 8'h55);
            step(1'b0, 1'b0, 12'd4, 8'hAA);
          end
          step(1'b1, (r == 0 && c == 0), 12'd4, 8'(16 * r + c));
        end
        k++;
      end
    end
  endtask

  // Generic frame: sof on the first accept with lw0, later accepts drive lw1.
  task automatic frame_gen(input int n, input logic [CW-1:0] lw0, input logic [CW-1:0] lw1,
                           input logic [7:0] base);
    for (int k = 0; k < n; k++)
      step(1'b1, (k == 0), (k == 0) ? lw0 : lw1, base + 8'(k));
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.sof = 1'b0; bus.line_width = '0; bus.d_in = '0;
    model_reset();

    tag = "reset";      do_reset(); do_reset();
    tag = "basic";      frame4(1'b0, 16);
    tag = "gap";        frame4(1'b1, 16);
    tag = "midrst";     frame4(1'b0, 12); do_reset();
    tag = "afterrst";   frame4(1'b0, 16);
    tag = "midsof";     frame_gen(6, 12'd4, 12'd4, 8'h40);
                        frame_gen(15, 12'd5, 12'd5, 8'h80);
    tag = "lw0";        frame_gen(24, 12'd0, 12'd0, 8'h10);
    tag = "lw9";        frame_gen(24, 12'd9, 12'd9, 8'h30);
    tag = "lwchg";      frame_gen(4, 12'd4, 12'd4, 8'h60);
                        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 12'd6, 8'h70 + 8'(k));
    tag = "idle";       step(1'b0, 1'b0, 12'd6, 8'h00);
    tag = "rowsat";     frame_gen(4100, 12'd1, 12'd1, 8'h00);

    checks++;
    assert (sbq.size() == 0) else begin
      failures++;
      $error("FAIL final sb_leftover got=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cfa_window_buffer.md
Name: cfa_window_buffer

Overview:
- Parametrised successor to the fixed 3x3 / 8-bit CFA neighbourhood buffer.
- Accepts a raster-ordered raw Bayer pixel stream and presents a registered KxK neighbourhood window to the demosaic datapath.
- Adds a runtime line width, frame-start alignment, a window-valid qualifier, centre coordinates and the CFA phase of the centre pixel.
- Line storage is K-1 line memories of depth IMG_W, plus a KxK register array.

Parameters:
- PIX_W, 8, bits per pixel.
- K, 3, window size; odd, >=3.
- IMG_W, 640, maximum line width in pixels; sets line-memory depth.
- CW, 12, width of the row/column counters and coordinate outputs; 2^CW > IMG_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  pixel-accept strobe; d_in is consumed on a rising edge of clk when en=1
- sof  in  1  start of frame; qualified by en; marks d_in as pixel (0,0)
- line_width  in  CW  active pixels per line, 1..IMG_W; sampled only on an accepted sof
- d_in  in  PIX_W  input pixel
- window_data  out  K*K*PIX_W  window; element (r,c) at bits [(r*K+c)*PIX_W +: PIX_W]; r=0 is the oldest row, c=0 is the oldest column
- win_valid  out  1  window_data holds a complete, non-wrapping window
- ctr_row  out  CW  row of the window centre pixel
- ctr_col  out  CW  column of the window centre pixel
- bayer_phase  out  2  {ctr_row[0], ctr_col[0]}

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - window_data, win_valid, ctr_row, ctr_col and bayer_phase are 0.
  - Row and column counters are 0; stored width is IMG_W.
  - Line-memory contents are don't-care.
  - Reset mid-frame abandons the frame. The next pixel accepted without sof is treated as (0,0) at the stored IMG_W width.
- Accept cycle (en=1), pixel p at position (r,c):
  - The write goes to line memories at address c.
  - The column shift registers take the K-1 stored pixels at column c plus p.
  - After the same edge, window_data holds rows r-K+1..r and columns c-K+1..c.
  - Latency is 1 clock from accept to output.
- win_valid:
  - Registered.
  - After an accept edge: win_valid = (r>=K-1) && (c>=K-1).
  - After any edge with en=0: win_valid=0, and window_data and the ctr_* outputs hold their values.
  - win_valid is therefore at most a one-cycle pulse per accepted pixel.
- Centre coordinates, updated with every accept: ctr_row = r-(K-1)/2, ctr_col = c-(K-1)/2, modulo 2^CW. They are meaningful only while win_valid=1.
- Counters:
  - After an accept, c increments.
  - When c = width-1, the next pixel goes to c=0 and r+1.
  - r saturates at 2^CW-1.
- sof:
  - An accepted sof forces the current pixel to (0,0).
  - It loads the stored width from line_width; a value of 0 or greater than IMG_W is clamped to IMG_W.
  - sof with en=0 is ignored.
  - sof is legal mid-line; the partial line is discarded.
- line_width changes without an accepted sof have no effect.
- Windows at the start of each line (c<K-1) contain stale columns from the previous line. Their win_valid is 0.
- Line memories: single write and single read per accept, at the same address. Read-before-write ordering is required, so the old value is returned.

Test Plan:
- K=3, PIX_W=8, IMG_W=8, line_width=4; sof on the first pixel; pixel value = 16*r+c over 4 lines, continuous en.
  - win_valid pulses on exactly 4 accepts: (2,2), (2,3), (3,2), (3,3).
  - After (2,2): elements 0..8 = 00,01,02,10,11,12,20,21,22 (hex); ctr=(1,1); bayer_phase=2'b11.
  - After (3,3): elements 11,12,13,21,22,23,31,32,33; ctr=(2,2); bayer_phase=2'b00.
- Same stream with en low for 3 cycles between (2,1) and (2,2):
  - Outputs frozen during the gap; win_valid=0 during the gap.
  - Results after (2,2) are identical to the first scenario.
- rst=1 for one cycle after (2,3):
  - All outputs 0 on the next cycle.
  - A new sof frame then reproduces the first scenario exactly.
- sof asserted mid-line at (1,2) with line_width=5:
  - Counting restarts at (0,0).
  - The first win_valid occurs at new pixel (2,2).
  - Rows wrap after column 4.
- line_width set to 0 and to 9 at sof: both behave as width 8; the line wrap occurs after column 7.
- line_width changed from 4 to 6 mid-frame without sof: wrap still occurs after column 3.
